// File: rtl/car_direction_detector_if.sv
// car_direction_detector_if: raw gate sensor levels in, conditioned levels and crossing pulses out
interface car_direction_detector_if;
  logic outer;
  logic inner;
  logic enter;
  logic exit;
  logic abort;
  logic outer_clean;
  logic inner_clean;
  modport master(output outer, inner, input enter, exit, abort, outer_clean, inner_clean);
  modport slave(input outer, inner, output enter, exit, abort, outer_clean, inner_clean);
endinterface

// File: rtl/car_direction_detector.sv
// car_direction_detector: synchronizes gate sensors and emits one enter/exit/abort pulse per crossing
// Optional debounce filter compiled in with `define CAR_DIRECTION_DEBOUNCE_EN.
module car_direction_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  car_direction_detector_if.slave bus
);
  typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT_CLR} state_t;
  state_t state;
  logic [1:0] sync [SYNC_STAGES];
  logic [1:0] clean;
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("car_direction_detector: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end
  // bit 1 carries outer, bit 0 carries inner
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
    else begin
      sync[0] <= {bus.outer, bus.inner};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
`ifdef CAR_DIRECTION_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt [2];
  always_ff @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (reset) begin
        cnt[i] <= '0;
        clean[i] <= 1'b0;
      end else if (sync[SYNC_STAGES-1][i] == clean[i])
        cnt[i] <= '0;
      else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        clean[i] <= sync[SYNC_STAGES-1][i];
        cnt[i] <= '0;
      end else
        cnt[i] <= cnt[i] + 1'b1;
`else
  assign clean = sync[SYNC_STAGES-1];
`endif
  assign bus.outer_clean = clean[1];
  assign bus.inner_clean = clean[0];
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      bus.enter <= 1'b0;
      bus.exit <= 1'b0;
      bus.abort <= 1'b0;
    end else begin
      bus.enter <= 1'b0;
      bus.exit <= 1'b0;
      bus.abort <= 1'b0;
      case (state)
        IDLE:
          if (clean == 2'b10) state <= IN1;
          else if (clean == 2'b01) state <= OUT1;
          else if (clean == 2'b11) begin state <= WAIT_CLR; bus.abort <= 1'b1; end
        IN1:
          if (clean == 2'b11) state <= IN2;
          else if (clean == 2'b00) begin state <= IDLE; bus.abort <= 1'b1; end
          else if (clean == 2'b01) begin state <= WAIT_CLR; bus.abort <= 1'b1; end
        IN2:
          if (clean == 2'b01) state <= IN3;
          else if (clean == 2'b10) state <= IN1;
          else if (clean == 2'b00) begin state <= IDLE; bus.abort <= 1'b1; end
        IN3:
          if (clean == 2'b00) begin state <= IDLE; bus.enter <= 1'b1; end
          else if (clean == 2'b11) state <= IN2;
          else if (clean == 2'b10) begin state <= WAIT_CLR; bus.abort <= 1'b1; end
        OUT1:
          if (clean == 2'b11) state <= OUT2;
          else if (clean == 2'b00) begin state <= IDLE; bus.abort <= 1'b1; end
          else if (clean == 2'b10) begin state <= WAIT_CLR; bus.abort <= 1'b1; end
        OUT2:
          if (clean == 2'b10) state <= OUT3;
          else if (clean == 2'b01) state <= OUT1;
          else if (clean == 2'b00) begin state <= IDLE; bus.abort <= 1'b1; end
        OUT3:
          if (clean == 2'b00) begin state <= IDLE; bus.exit <= 1'b1; end
          else if (clean == 2'b11) state <= OUT2;
          else if (clean == 2'b01) begin state <= WAIT_CLR; bus.abort <= 1'b1; end
        default:
          if (clean == 2'b00) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_car_direction_detector.sv
// tb_car_direction_detector: scoreboard bench with a path-position reference model
module tb_car_direction_detector;
  localparam int SYNC = 2;
  localparam int DEB = 4;
`ifdef CAR_DIRECTION_DEBOUNCE_EN
  localparam int LAT = SYNC + 1 + DEB;
`else
  localparam int LAT = SYNC + 1;
`endif
  typedef struct {int kind; int cyc;} ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  ev_t q[$];
  int dir = 0;
  int pos = 0;
  logic [1:0] prev = 2'b00;
  car_direction_detector_if bus();
  car_direction_detector #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // position along the path in the given direction: 1 first sensor, 2 both, 3 second sensor, 0 clear
  function automatic int rank(int d, logic [1:0] v);
    return v == 2'b11 ? 2 : v == 2'b00 ? 0 : ((d == 1) == (v == 2'b10)) ? 1 : 3;
  endfunction
  // dir: 0 idle, 1 entering, -1 exiting, 2 waiting for clear; returns 0 none, 1 enter, 2 exit, 3 abort
  function automatic int model(logic [1:0] v);
    int r;
    int p;
    r = 0;
    if (v == prev) return 0;
    prev = v;
    if (dir == 2) begin
      if (v == 2'b00) dir = 0;
    end else if (dir == 0) begin
      if (v == 2'b11) begin dir = 2; r = 3; end
      else if (v != 2'b00) begin dir = (v == 2'b10) ? 1 : -1; pos = 1; end
    end else begin
      p = rank(dir, v);
      if (p == 0) begin
        r = (pos != 3) ? 3 : (dir == 1) ? 1 : 2;
        dir = 0;
      end else if (p - pos == 1 || pos - p == 1) pos = p;
      else begin dir = 2; r = 3; end
    end
    return r;
  endfunction
  task automatic level(logic [1:0] v, int n);
    int r;
    @(posedge clk);
    #1;
    if (q.size() != 0 && q[0].cyc < cyc) check("overdue_pulse", q[0].cyc, -1);
    {bus.outer, bus.inner} = v;
    r = model(v);
    if (r != 0) q.push_back('{r, cyc + LAT});
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("clean_levels", {bus.outer_clean, bus.inner_clean}, v);
  endtask
  task automatic seq4(logic [1:0] a, logic [1:0] b, logic [1:0] c, logic [1:0] d);
    level(a, 9);
    level(b, 9);
    level(c, 9);
    level(d, 9);
  endtask
  task automatic check_idle_outputs();
    check("enter_idle", bus.enter, 0);
    check("exit_idle", bus.exit, 0);
    check("abort_idle", bus.abort, 0);
    check("outer_clean_idle", bus.outer_clean, 0);
    check("inner_clean_idle", bus.inner_clean, 0);
  endtask
  always @(negedge clk)
    if (!reset && (bus.enter || bus.exit || bus.abort)) begin
      int k;
      ev_t e;
      k = bus.enter ? 1 : bus.exit ? 2 : 3;
      check("pulse_onehot", $countones({bus.enter, bus.exit, bus.abort}), 1);
      if (q.size() == 0) check("unexpected_pulse", k, 0);
      else begin
        e = q.pop_front();
        check("pulse_kind", k, e.kind);
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  initial begin
    {bus.outer, bus.inner} = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs();
    level(2'b00, 20);
    repeat (4) seq4(2'b10, 2'b11, 2'b01, 2'b00);
    seq4(2'b01, 2'b11, 2'b10, 2'b00);
    seq4(2'b10, 2'b11, 2'b10, 2'b00);
    seq4(2'b10, 2'b00, 2'b01, 2'b00);
    level(2'b11, 9);
    level(2'b01, 9);
    level(2'b00, 9);
    level(2'b10, 9);
    level(2'b11, 9);
    level(2'b01, 9);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    {bus.outer, bus.inner} = 2'b00;
    dir = 0;
    pos = 0;
    prev = 2'b00;
    @(negedge clk);
    check_idle_outputs();
    level(2'b00, 12);
    seq4(2'b10, 2'b11, 2'b01, 2'b00);
`ifdef CAR_DIRECTION_DEBOUNCE_EN
    @(posedge clk);
    #1;
    bus.outer = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.outer = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("glitch_outer_clean", bus.outer_clean, 0);
    end
`endif
    repeat (60) level(2'($urandom_range(0, 3)), int'($urandom_range(LAT + 1, 12)));
    level(2'b00, 20);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
